// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the FSM state enum, register map addresses and vector helper.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SAFE = 2'd1,
        ISSUE     = 2'd2,
        SERVICE   = 2'd3
    } ic_state_t;

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int VECTOR_STRIDE = 4;

    // Handler address, wrapping modulo 2^16.
    function automatic logic [15:0] vec_addr(
        input logic [15:0] base,
        input logic [3:0]  id
    );
        return base + 16'(id) * 16'(VECTOR_STRIDE);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Configuration register bus for the interrupt controller.
// Ports: cfg_wren/cfg_addr/cfg_wdata driven by master, cfg_rdata by slave.
interface interrupt_controller_if;

    logic        cfg_wren;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;

    modport master (
        output cfg_wren,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_wren,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );

endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Combinational lowest-index-first priority encoder.
// Ports: req (N bits) in; found (any set) and idx (4-bit winner) out.
module irq_priority_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [3:0]   idx
);

    // Scan high to low so the lowest set bit is written last.
    always_comb begin
        found = 1'b0;
        idx   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller with mask/pending/ctrl registers,
// lowest-index arbitration and a safe-point issue FSM (no nesting).
// Ports: clk, rst (sync, active-low), irq lines, cfg bus (slave),
// hazard/decoder_output_flush/pc_ret1 from the pipeline,
// interrupt pulse, int_vector handler address, int_active in service.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq,
    interrupt_controller_if.slave cfg,
    input  logic                 hazard,
    input  logic                 decoder_output_flush,
    input  logic                 pc_ret1,
    output logic                 interrupt,
    output logic [15:0]          int_vector,
    output logic                 int_active
);

    ic_state_t          state;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] irq_q;
    logic               en;
    logic [3:0]         act_id;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] iss_clr;
    logic [NUM_IRQ-1:0] elig;
    logic               found;
    logic [3:0]         win_id;
    logic               issue_go;
    logic               unused_wdata;

    assign unused_wdata = ^cfg.cfg_wdata;

    assign rise = irq & ~irq_q;
    assign elig = pend & mask;

    irq_priority_encoder #(
        .N (NUM_IRQ)
    ) u_prio (
        .req   (elig),
        .found (found),
        .idx   (win_id)
    );

    assign issue_go = (state == WAIT_SAFE) && en && found
                   && !hazard && !decoder_output_flush;

    always_comb begin
        w1c = '0;
        if (cfg.cfg_wren && cfg.cfg_addr == ADDR_PEND)
            w1c = cfg.cfg_wdata[NUM_IRQ-1:0];
    end

    always_comb begin
        iss_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            iss_clr[i] = issue_go && (win_id == 4'(i));
    end

    always_comb begin
        cfg.cfg_rdata = '0;
        unique case (cfg.cfg_addr)
            ADDR_MASK:   cfg.cfg_rdata = 16'(mask);
            ADDR_PEND:   cfg.cfg_rdata = 16'(pend);
            ADDR_CTRL:   cfg.cfg_rdata = {15'd0, en};
            ADDR_STATUS: cfg.cfg_rdata = {int_active, 11'd0, act_id};
        endcase
    end

    // Register file and edge detect; a new edge beats any clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask  <= '0;
            pend  <= '0;
            irq_q <= '0;
            en    <= 1'b0;
        end else begin
            irq_q <= irq;
            pend  <= (pend & ~(w1c | iss_clr)) | rise;
            if (cfg.cfg_wren && cfg.cfg_addr == ADDR_MASK)
                mask <= cfg.cfg_wdata[NUM_IRQ-1:0];
            if (cfg.cfg_wren && cfg.cfg_addr == ADDR_CTRL)
                en <= cfg.cfg_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            int_active <= 1'b0;
            int_vector <= VECTOR_BASE;
            act_id     <= 4'd0;
        end else begin
            interrupt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && found)
                        state <= WAIT_SAFE;
                end
                WAIT_SAFE: begin
                    if (!en || !found) begin
                        state <= IDLE;
                    end else if (issue_go) begin
                        state      <= ISSUE;
                        interrupt  <= 1'b1;
                        act_id     <= win_id;
                        int_vector <= vec_addr(VECTOR_BASE, win_id);
                    end
                end
                ISSUE: begin
                    state      <= SERVICE;
                    int_active <= 1'b1;
                end
                SERVICE: begin
                    if (pc_ret1) begin
                        state      <= IDLE;
                        int_active <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Inputs change on the falling edge; outputs are checked there too.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic       hazard;
    logic       flush;
    logic       pc_ret1;
    logic       interrupt;
    logic [15:0] int_vector;
    logic       int_active;

    int nerr = 0;
    int nchk = 0;

    interrupt_controller_if cfg ();

    interrupt_controller #(
        .NUM_IRQ     (8),
        .VECTOR_BASE (16'h0010)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .irq                  (irq),
        .cfg                  (cfg),
        .hazard               (hazard),
        .decoder_output_flush (flush),
        .pc_ret1              (pc_ret1),
        .interrupt            (interrupt),
        .int_vector           (int_vector),
        .int_active           (int_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg.cfg_wren  = 1'b1;
        cfg.cfg_addr  = a;
        cfg.cfg_wdata = d;
        cyc(1);
        cfg.cfg_wren  = 1'b0;
        cfg.cfg_wdata = 16'h0000;
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [15:0] exp);
        cfg.cfg_addr = a;
        #1;
        chk(tag, cfg.cfg_rdata, exp);
    endtask

    task automatic ret();
        pc_ret1 = 1'b1;
        cyc(1);
        pc_ret1 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        irq = 8'h00;
        hazard = 1'b0;
        flush = 1'b0;
        pc_ret1 = 1'b0;
        cfg.cfg_wren = 1'b0;
        cfg.cfg_addr = 2'd0;
        cfg.cfg_wdata = 16'h0000;
        cyc(2);

        // reset state
        chk("rst_int", {15'd0, interrupt}, 16'h0);
        chk("rst_act", {15'd0, int_active}, 16'h0);
        chk("rst_vec", int_vector, 16'h0010);
        rd("rst_mask", 2'd0, 16'h0000);
        rd("rst_pend", 2'd1, 16'h0000);
        rd("rst_ctrl", 2'd2, 16'h0000);
        rd("rst_stat", 2'd3, 16'h0000);
        rst = 1'b1;
        cyc(1);

        // single irq 0, minimum latency
        wr(2'd0, 16'hFF01);
        rd("mask_rd", 2'd0, 16'h0001);
        wr(2'd2, 16'hFFFF);
        rd("ctrl_rd", 2'd2, 16'h0001);
        irq[0] = 1'b1;
        cyc(1);
        chk("t1_c1_int", {15'd0, interrupt}, 16'h0);
        rd("t1_pend1", 2'd1, 16'h0001);
        cyc(1);
        chk("t1_c2_int", {15'd0, interrupt}, 16'h0);
        cyc(1);
        chk("t1_c3_int", {15'd0, interrupt}, 16'h1);
        chk("t1_vec", int_vector, 16'h0010);
        rd("t1_pend0", 2'd1, 16'h0000);
        cyc(1);
        chk("t1_pulse1", {15'd0, interrupt}, 16'h0);
        chk("t1_act", {15'd0, int_active}, 16'h1);
        rd("t1_stat", 2'd3, 16'h8000);
        ret();
        chk("t1_done", {15'd0, int_active}, 16'h0);
        irq = 8'h00;

        // two edges together, lowest index first
        wr(2'd0, 16'h00FF);
        irq[5] = 1'b1;
        irq[2] = 1'b1;
        cyc(3);
        chk("t2_int_a", {15'd0, interrupt}, 16'h1);
        chk("t2_vec_a", int_vector, 16'h0018);
        cyc(1);
        rd("t2_stat_a", 2'd3, 16'h8002);
        rd("t2_pend", 2'd1, 16'h0020);
        cyc(3);
        chk("t2_nonest", {15'd0, interrupt}, 16'h0);
        ret();
        chk("t2_ret", {15'd0, int_active}, 16'h0);
        cyc(2);
        chk("t2_int_b", {15'd0, interrupt}, 16'h1);
        chk("t2_vec_b", int_vector, 16'h0024);
        cyc(1);
        rd("t2_stat_b", 2'd3, 16'h8005);
        ret();
        irq = 8'h00;

        // hazard stall, preempted by a later irq 0
        hazard = 1'b1;
        irq[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) irq[0] = 1'b1;
            cyc(1);
            chk($sformatf("t3_stall%0d", i),
                {15'd0, interrupt}, 16'h0);
        end
        hazard = 1'b0;
        cyc(1);
        chk("t3_int", {15'd0, interrupt}, 16'h1);
        chk("t3_vec", int_vector, 16'h0010);
        cyc(1);
        chk("t3_pulse1", {15'd0, interrupt}, 16'h0);
        rd("t3_pend", 2'd1, 16'h0002);
        ret();
        cyc(2);
        chk("t3_int_b", {15'd0, interrupt}, 16'h1);
        chk("t3_vec_b", int_vector, 16'h0014);
        cyc(1);
        ret();
        irq = 8'h00;

        // disable while waiting, then re-enable behind a flush
        hazard = 1'b1;
        irq[4] = 1'b1;
        cyc(2);
        wr(2'd2, 16'h0000);
        cyc(1);
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("t4_off%0d", i),
                {15'd0, interrupt}, 16'h0);
        end
        rd("t4_pend", 2'd1, 16'h0010);
        flush = 1'b1;
        wr(2'd2, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("t4_flush%0d", i),
                {15'd0, interrupt}, 16'h0);
        end
        flush = 1'b0;
        cyc(1);
        chk("t4_int", {15'd0, interrupt}, 16'h1);
        chk("t4_vec", int_vector, 16'h0020);
        cyc(1);
        ret();
        irq = 8'h00;

        // W1C racing a new edge on the same bit
        wr(2'd2, 16'h0000);
        irq[3] = 1'b1;
        cyc(1);
        rd("t5_pend_a", 2'd1, 16'h0008);
        irq[3] = 1'b0;
        cyc(1);
        irq[3] = 1'b1;
        wr(2'd1, 16'h0008);
        rd("t5_race", 2'd1, 16'h0008);
        wr(2'd1, 16'h0008);
        rd("t5_w1c", 2'd1, 16'h0000);
        irq = 8'h00;

        // reset during service
        wr(2'd2, 16'h0001);
        irq[6] = 1'b1;
        irq[7] = 1'b1;
        cyc(3);
        chk("t6_int", {15'd0, interrupt}, 16'h1);
        chk("t6_vec", int_vector, 16'h0028);
        cyc(1);
        chk("t6_act", {15'd0, int_active}, 16'h1);
        rst = 1'b0;
        irq = 8'h00;
        cyc(1);
        chk("t6_r_act", {15'd0, int_active}, 16'h0);
        chk("t6_r_int", {15'd0, interrupt}, 16'h0);
        chk("t6_r_vec", int_vector, 16'h0010);
        rd("t6_r_mask", 2'd0, 16'h0000);
        rd("t6_r_pend", 2'd1, 16'h0000);
        rd("t6_r_ctrl", 2'd2, 16'h0000);
        rd("t6_r_stat", 2'd3, 16'h0000);
        rst = 1'b1;
        ret();
        cyc(2);
        chk("t6_ret_act", {15'd0, int_active}, 16'h0);
        chk("t6_ret_int", {15'd0, interrupt}, 16'h0);
        rd("t6_ret_stat", 2'd3, 16'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, meaning number of interrupt request lines (range 1..16).
REQ-002 SHALL have parameter VECTOR_BASE, default 16'h0010, meaning handler vector of irq 0.
REQ-003 SHALL have the port list, clock and reset first: clk  in  1  single system clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 irq  in  NUM_IRQ  level request lines, synchronous to clk.
REQ-006 cfg_wren  in  1  config register write strobe.
REQ-007 cfg_addr  in  2  config register select.
REQ-008 cfg_wdata  in  16  config write data.
REQ-009 cfg_rdata  out  16  config read data, combinational on cfg_addr.
REQ-010 hazard  in  1  pipeline stall from hazard unit.
REQ-011 decoder_output_flush  in  1  branch/call/return redirect in flight.
REQ-012 pc_ret1  in  1  return executing in stage 1 (end of handler).
REQ-013 interrupt  out  1  one-cycle entry pulse to hazard unit and PC logic.
REQ-014 int_vector  out  16  handler address, valid while interrupt=1 and held until next issue.
REQ-015 int_active  out  1  handler in service.

Function
REQ-016 Register map SHALL be: addr 0 MASK (rw, bit i enables irq i); addr 1 PENDING (read; write-1-to-clear); addr 2 CTRL (bit 0 global enable, rw); addr 3 STATUS (read: bit 15 int_active, bits 3:0 active id).
REQ-017 Unused or out-of-range bits SHALL read 0 and ignore writes.
REQ-018 A 0->1 transition on irq[i], seen against a registered copy, SHALL set PENDING[i] on the next edge.
REQ-019 A set and a clear of the same PENDING bit in one cycle SHALL resolve with set winning.
REQ-020 Eligible set SHALL be PENDING & MASK; the winner SHALL be the lowest-index eligible bit.
REQ-021 FSM states SHALL be IDLE, WAIT_SAFE, ISSUE, SERVICE.
REQ-022 IDLE: go to WAIT_SAFE when CTRL[0]=1 and eligible set is non-zero.
REQ-023 WAIT_SAFE: re-arbitrate every cycle; go to IDLE if eligible set is empty or CTRL[0]=0; go to ISSUE when hazard=0 and decoder_output_flush=0.
REQ-024 ISSUE: lasts exactly one cycle with interrupt=1; latch winner id; clear its PENDING bit; go to SERVICE.
REQ-025 int_vector SHALL be (VECTOR_BASE + id*4) mod 2^16.
REQ-026 SERVICE: int_active=1, with no nesting; go to IDLE on pc_ret1=1.
REQ-027 A pc_ret1 outside SERVICE SHALL be ignored.
REQ-028 Minimum latency from irq edge to the interrupt pulse SHALL be 3 cycles: PENDING set, then WAIT_SAFE, then ISSUE.
REQ-029 interrupt SHALL never be 1 in two consecutive cycles.

Reset
REQ-030 While rst=0 at a clock edge: MASK=0, PENDING=0, CTRL=0, edge registers=0, FSM=IDLE, interrupt=0, int_active=0, int_vector=VECTOR_BASE, active id=0.
REQ-031 Reset asserted mid-operation, in any state, SHALL return to IDLE and discard pending requests.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the register address constants and VECTOR_STRIDE=4.
REQ-033 One sub-module, irq_priority_encoder (NUM_IRQ-bit in, found flag plus 4-bit index out, combinational), SHALL be used.

Verification
REQ-034 MASK=8'h01, CTRL=1, irq[0] rises, hazard=0 -> interrupt pulses 3 cycles later, int_vector=16'h0010, PENDING[0]=0, int_active=1.
REQ-035 irq[5] and irq[2] rise together, MASK=8'hFF -> id 2 issued, vector 16'h0018; after pc_ret1, id 5 issued, vector 16'h0024.
REQ-036 Pending irq[1] with hazard=1 for 10 cycles -> no pulse; pulse arrives the cycle after hazard falls; an irq[0] edge during the wait preempts and issues id 0.
REQ-037 In WAIT_SAFE, write CTRL=0 -> FSM returns to IDLE with no pulse; PENDING bit stays 1; re-enable -> issue.
REQ-038 W1C write to PENDING[3] in the same cycle as a new irq[3] edge -> PENDING[3] reads 1.
REQ-039 rst=0 for one cycle during SERVICE -> all registers at reset values, int_active=0, and a later pc_ret1 has no effect.
